div_iter: RTL and testbench

//   Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. Sits directly under the

---
 rtl/div_iter.sv | 147 ++++++++++++++
 tb/tb_div_iter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Purpose : multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, result {HI, LO} = {rem, quo}.
// Latency : accept at edge T, res_valid first high after edge T+WIDTH+2, held until handshake.
// Backpr. : result is held in DONE while res_ready is low; opn_valid low aborts any op in flight.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset; the ALU also drives it for pipeline flush
//   a, b       dividend / divisor, sampled only on the accept edge
//   sign       1 = signed DIV, 0 = unsigned DIVU, sampled only on the accept edge
//   opn_valid  operands valid; must stay high for the whole operation
//   res_ready  consumer can take the result
//   res_valid  result valid (DONE state only)
//   result     {remainder, quotient}
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sign,
  input  logic                 opn_valid,
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;      // partial remainder (magnitude)
  logic [WIDTH-1:0] quo;      // dividend bits shift out of the top, quotient bits in at bit 0
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] a_raw;    // untouched dividend, needed for the divide-by-zero result
  logic             q_neg;
  logic             r_neg;
  logic             b_zero;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    // Magnitudes: the most negative value maps onto itself, which is the correct
    // unsigned magnitude, so no special case is needed for MIN.
    a_mag   = (sign && a[WIDTH-1]) ? -a : a;
    b_mag   = (sign && b[WIDTH-1]) ? -b : b;
    // Next dividend bit enters the partial remainder from the top of quo.
    shifted = {rem, quo[WIDTH-1]};
    // One extra bit so the MSB of trial is the borrow of the trial subtraction.
    trial   = {1'b0, shifted} - {2'b00, dvs};
    quo_fix = q_neg ? -quo : quo;
    rem_fix = r_neg ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      a_raw     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      b_zero    <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          if (opn_valid) begin
            rem    <= '0;
            quo    <= a_mag;
            dvs    <= b_mag;
            a_raw  <= a;
            q_neg  <= (a[WIDTH-1] ^ b[WIDTH-1]) & sign;
            r_neg  <= a[WIDTH-1] & sign;
            b_zero <= (b == '0);
            count  <= '0;
            state  <= BUSY;
          end
        end

        BUSY: begin
          if (!opn_valid) begin
            state <= IDLE;
          end else if (count == CW'(WIDTH)) begin
            // All quotient bits are in; the edge spent here gives the
            // WIDTH+2 accept-to-valid latency the ALU expects.
            state <= FIX;
          end else begin
            if (!trial[WIDTH+1]) begin
              // Difference is non-negative and, since rem < dvs, fits in WIDTH bits.
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            count <= count + CW'(1);
          end
        end

        FIX: begin
          if (!opn_valid) begin
            state <= IDLE;
          end else begin
            if (b_zero) begin
              result <= {a_raw, {WIDTH{1'b1}}};
            end else begin
              result <= {rem_fix, quo_fix};
            end
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Leaving DONE always takes one IDLE cycle before the next accept.
          if (!opn_valid || res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Purpose : self-checking bench for div_iter against an arithmetic reference model.
// Latency : checks the accept-to-valid latency of every operation.
// Backpr. : exercises result hold under res_ready low, abort and reset cancel.
module tb_div_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sign;
  logic          opn_valid;
  logic          res_ready;
  logic          res_valid;
  logic [2*W-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sign      (sign),
    .opn_valid (opn_valid),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .result    (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain language-level division.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint   sx, sy, q, r;
    logic [31:0] uq, ur;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    uq = x / y;
    ur = x % y;
    return {ur, uq};
  endfunction

  // Called right after the accept edge has been armed (opn_valid high in IDLE).
  task automatic wait_done(input logic [63:0] exp, input int hold, input string tag);
    int n;
    @(posedge clk); #1;
    // Operands must be ignored after accept.
    a    = $urandom;
    b    = $urandom;
    sign = 1'($urandom_range(0, 1));
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd34);
    check({tag, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 64'(res_valid), 64'd1);
      check({tag, " hold result"}, result, exp);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " valid drop"}, 64'(res_valid), 64'd0);
    res_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                        input int hold, input string tag);
    a         = oa;
    b         = ob;
    sign      = os;
    opn_valid = 1'b1;
    res_ready = (hold == 0);
    wait_done(model(oa, ob, os), hold, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int n;
    logic [31:0] ra, rb;
    logic        rs;
    int          pick;

    rst = 1'b1; opn_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0, 0, "udiv 100/7");
    check("100/7 const", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "sdiv -7/2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "sdiv 7/-2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "sdiv MIN/-1");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "udiv MIN/max");
    run_op(32'h1234_5678, 32'd0, 1'b1, 0, "sdiv by 0");
    run_op(32'h1234_5678, 32'd0, 1'b0, 0, "udiv by 0");

    // Hold in DONE, then a back-to-back op accepted one cycle after the handshake
    run_op(32'd1000, 32'd33, 1'b0, 5, "hold 5");
    run_op(32'd9, 32'd3, 1'b0, 0, "b2b 9/3");

    // Reset mid-BUSY, with opn_valid left high and new operands
    a = 32'd12345; b = 32'd77; sign = 1'b0; opn_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; a = 32'd50; b = 32'd5; sign = 1'b0;
    @(posedge clk); #1;
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst result", result, 64'd0);
    rst = 1'b0;
    wait_done(model(32'd50, 32'd5, 1'b0), 0, "after rst 50/5");

    // Abort mid-BUSY: never any res_valid, result keeps its last value
    a = 32'd1000; b = 32'd3; sign = 1'b0; opn_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    opn_valid = 1'b0;
    hi = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) hi++;
    end
    check("abort busy no valid", 64'(hi), 64'd0);
    check("abort busy result kept", result, {32'd0, 32'd10});

    // Abort while waiting in DONE
    a = 32'd77; b = 32'd8; sign = 1'b0; opn_valid = 1'b1; res_ready = 1'b0;
    n = 0;
    @(posedge clk); #1;
    while (res_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort done latency", 64'(n), 64'd34);
    opn_valid = 1'b0;
    @(posedge clk); #1;
    check("abort done valid", 64'(res_valid), 64'd0);
    check("abort done result kept", result, {32'd5, 32'd9});
    @(posedge clk); #1;

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      ra   = $urandom;
      rs   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      case (pick)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ra, rb, rs, $urandom_range(0, 3), $sformatf("rand%0d %h/%h s%0d", k, ra, rb, rs));
      if ($urandom_range(0, 2) == 0) begin
        opn_valid = 1'b0;
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
